rcc_vcore_scan_cap: RTL and testbench

RCC_VCORE_SCAN_CAP -- requirements
Module: rcc_vcore_scan_cap

---
 rtl/rcc_vcore_scan_pkg.sv | 46 ++++
 rtl/rcc_vcore_edge_cnt.sv | 43 ++++
 rtl/rcc_vcore_scan_cap.sv | 157 +++++++++++++++
 tb/tb_rcc_vcore_scan_cap.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rcc_vcore_scan_pkg.sv
// Shared definitions for the vcore scan-capture block: FSM encoding, command and
// status bit positions, and the status word packer.
package rcc_vcore_scan_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSync  = 2'd1,
      StCount = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Write word fields
   localparam int unsigned WdStart  = 31;
   localparam int unsigned WdAbort  = 30;
   localparam int unsigned WdClr    = 29;
   localparam int unsigned WdWinMsb = 15;

   // Status word fields
   localparam int unsigned RdDone    = 31;
   localparam int unsigned RdBusy    = 30;
   localparam int unsigned RdErr     = 29;
   localparam int unsigned RdNrst    = 28;
   localparam int unsigned RdMco1Lsb = 16;
   localparam int unsigned RdMco2Lsb = 8;
   localparam int unsigned RdPllLsb  = 0;

   function automatic logic [31:0] pack_status(input logic       done,
                                               input logic       busy,
                                               input logic       err,
                                               input logic       nrst,
                                               input logic [7:0] mco1,
                                               input logic [7:0] mco2,
                                               input logic [7:0] pll);
      logic [31:0] s;
      s                        = '0;
      s[RdDone]                = done;
      s[RdBusy]                = busy;
      s[RdErr]                 = err;
      s[RdNrst]                = nrst;
      s[RdMco1Lsb +: 8]        = mco1;
      s[RdMco2Lsb +: 8]        = mco2;
      s[RdPllLsb +: 8]         = pll;
      return s;
   endfunction

endpackage

// File: rtl/rcc_vcore_edge_cnt.sv
// Probe path: multi-stage synchronizer, rising-edge detector and an 8-bit
// saturating edge counter.
module rcc_vcore_edge_cnt #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       async_i,
   input  logic       clr_i,
   input  logic       cnt_en_i,
   output logic [7:0] cnt_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [7:0]             cnt_q, cnt_d;
   logic                   rise;

   assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_en_i && rise && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/rcc_vcore_scan_cap.sv
// Vcore scan capture: counts synchronized probe edges over a programmed window and
// aborts the window with an error if the nrst_out probe falls.
module rcc_vcore_scan_cap
   import rcc_vcore_scan_pkg::*;
#(
   parameter int unsigned DW          = 32,
   parameter int unsigned WW          = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wen,
   input  logic [DW-1:0] wdata,
   input  logic [WW-1:0] wstrb,
   input  logic          ren,
   input  logic          nrst_out_scan_inc,
   input  logic          mco1_scan_inc,
   input  logic          mco2_scan_inc,
   input  logic          pll_src_clk_scan_inc,
   output logic          wready,
   output logic [DW-1:0] rdata,
   output logic          rvalid
);

   state_e                 state_q, state_d;
   logic [15:0]            tmr_q, tmr_d;
   logic [15:0]            win_q, win_d;
   logic                   err_q, err_d;
   logic [SYNC_STAGES-1:0] nrst_sync_q;
   logic                   nrst_prev_q;
   logic                   rvalid_q;
   logic [DW-1:0]          rdata_q;

   logic       cmd_start, cmd_abort, cmd_clr;
   logic       start_ok, cnt_en;
   logic       nrst_lvl, nrst_fall;
   logic [7:0] mco1_cnt, mco2_cnt, pll_cnt;
   logic       unused_wbits;

   assign unused_wbits = ^{wdata[28:16], wstrb[2]};

   assign cmd_start = wen & wstrb[3] & wdata[WdStart];
   assign cmd_abort = wen & wstrb[3] & wdata[WdAbort];
   assign cmd_clr   = wen & wstrb[3] & wdata[WdClr];

   assign wready    = (state_q == StIdle) || (state_q == StDone);
   assign nrst_lvl  = nrst_sync_q[SYNC_STAGES-1];
   assign nrst_fall = nrst_prev_q & ~nrst_lvl;

   // Edges on the last COUNT cycle (timeout or nrst fall) are deliberately not counted.
   assign cnt_en    = (state_q == StCount) && (state_d == StCount);

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      win_d    = win_q;
      err_d    = err_q;
      start_ok = 1'b0;

      case (state_q)
         StSync: begin
            if (tmr_q == 16'(SYNC_STAGES - 1)) begin
               tmr_d   = '0;
               state_d = (win_q == 16'd0) ? StDone : StCount;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         StCount: begin
            if (nrst_fall) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (tmr_q == (win_q - 16'd1)) begin
               state_d = StDone;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         default: ;
      endcase

      // Bus commands override the sequencing above; abort always wins.
      if (cmd_abort) begin
         state_d = StIdle;
         tmr_d   = '0;
      end else if (wen && !wready) begin
         err_d = 1'b1;
      end else if (cmd_start) begin
         start_ok = 1'b1;
         err_d    = 1'b0;
         tmr_d    = '0;
         state_d  = StSync;
         if (wstrb[0]) win_d[7:0]  = wdata[7:0];
         if (wstrb[1]) win_d[15:8] = wdata[WdWinMsb:8];
      end else if (cmd_clr && (state_q == StDone)) begin
         err_d   = 1'b0;
         state_d = StIdle;
      end
   end

   rcc_vcore_edge_cnt #(.SYNC_STAGES(SYNC_STAGES)) u_mco1 (
      .clk      (clk),
      .rst      (rst),
      .async_i  (mco1_scan_inc),
      .clr_i    (start_ok),
      .cnt_en_i (cnt_en),
      .cnt_o    (mco1_cnt)
   );

   rcc_vcore_edge_cnt #(.SYNC_STAGES(SYNC_STAGES)) u_mco2 (
      .clk      (clk),
      .rst      (rst),
      .async_i  (mco2_scan_inc),
      .clr_i    (start_ok),
      .cnt_en_i (cnt_en),
      .cnt_o    (mco2_cnt)
   );

   rcc_vcore_edge_cnt #(.SYNC_STAGES(SYNC_STAGES)) u_pll (
      .clk      (clk),
      .rst      (rst),
      .async_i  (pll_src_clk_scan_inc),
      .clr_i    (start_ok),
      .cnt_en_i (cnt_en),
      .cnt_o    (pll_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         tmr_q       <= '0;
         win_q       <= '0;
         err_q       <= 1'b0;
         nrst_sync_q <= '0;
         nrst_prev_q <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         win_q       <= win_d;
         err_q       <= err_d;
         nrst_sync_q <= {nrst_sync_q[SYNC_STAGES-2:0], nrst_out_scan_inc};
         nrst_prev_q <= nrst_lvl;
         rvalid_q    <= ren;
         // Status is taken from current registers, so a same-cycle write is not visible.
         rdata_q     <= ren ? pack_status(state_q == StDone,
                                          (state_q == StSync) || (state_q == StCount),
                                          err_q, nrst_lvl, mco1_cnt, mco2_cnt, pll_cnt)
                            : '0;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_rcc_vcore_scan_cap.sv
// Directed self-checking bench for rcc_vcore_scan_cap.
module tb_rcc_vcore_scan_cap;

   logic        clk;
   logic        rst;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ren;
   logic        nrst_in, mco1_in, mco2_in, pll_in;
   logic        wready;
   logic [31:0] rdata;
   logic        rvalid;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] d;
   logic        v;

   rcc_vcore_scan_cap #(
      .DW          (32),
      .WW          (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .wen                  (wen),
      .wdata                (wdata),
      .wstrb                (wstrb),
      .ren                  (ren),
      .nrst_out_scan_inc    (nrst_in),
      .mco1_scan_inc        (mco1_in),
      .mco2_scan_inc        (mco2_in),
      .pll_src_clk_scan_inc (pll_in),
      .wready               (wready),
      .rdata                (rdata),
      .rvalid               (rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] data, input logic [3:0] strb);
      wen   = 1'b1;
      wdata = data;
      wstrb = strb;
      tick();
      wen   = 1'b0;
      wdata = '0;
      wstrb = '0;
   endtask

   task automatic rd(output logic [31:0] data, output logic valid);
      ren = 1'b1;
      tick();
      ren   = 1'b0;
      data  = rdata;
      valid = rvalid;
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0; wstrb = '0;
      nrst_in = 1'b1; mco1_in = 1'b0; mco2_in = 1'b0; pll_in = 1'b0;
      repeat (3) tick();
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_wready", 32'(wready), 32'h1);
      rst = 1'b0;
      repeat (3) tick();

      // Idle status and read handshake
      rd(d, v);
      chk("idle_status", d, 32'h1000_0000);
      chk("idle_rvalid", 32'(v), 32'h1);
      tick();
      chk("rvalid_drop", 32'(rvalid), 32'h0);
      chk("rdata_zero", rdata, 32'h0);

      // 10-cycle window, three mco1 pulses
      wr(32'h8000_000A, 4'hF);
      chk("busy_wready", 32'(wready), 32'h0);
      repeat (3) tick();
      repeat (3) begin
         mco1_in = 1'b1; tick();
         mco1_in = 1'b0; tick();
      end
      repeat (6) tick();
      rd(d, v);
      chk("mco1_done", d, 32'h9003_0000);
      chk("done_wready", 32'(wready), 32'h1);

      // Abort beats simultaneous start; counters kept
      wr(32'hC000_0010, 4'hF);
      rd(d, v);
      chk("abort_idle", d, 32'h1003_0000);

      // Write while busy is dropped and flags err; window stays 20
      wr(32'h8000_0014, 4'hF);
      wr(32'h8000_0005, 4'hF);
      rd(d, v);
      chk("busy_err", d, 32'h7000_0000);
      repeat (19) tick();
      rd(d, v);
      chk("win20_last", d, 32'h7000_0000);
      rd(d, v);
      chk("win20_done", d, 32'hB000_0000);

      // clr_done with simultaneous read returns pre-write status
      wen = 1'b1; wdata = 32'h2000_0000; wstrb = 4'h8; ren = 1'b1;
      tick();
      wen = 1'b0; wdata = '0; wstrb = '0; ren = 1'b0;
      chk("rw_prewrite", rdata, 32'hB000_0000);
      rd(d, v);
      chk("clr_done", d, 32'h1000_0000);

      // Saturation over a 1024-cycle window
      wr(32'h8000_0400, 4'hF);
      for (int i = 0; i < 1100; i++) begin
         pll_in = ~pll_in;
         tick();
      end
      rd(d, v);
      chk("pll_sat", d, 32'h9000_00FF);

      // Zero window goes straight from SYNC to DONE
      wr(32'h8000_0000, 4'hF);
      tick();
      rd(d, v);
      chk("win0_sync", d, 32'h5000_0000);
      rd(d, v);
      chk("win0_done", d, 32'h9000_0000);

      // No low strobes: window keeps previous value (0)
      wr(32'h8000_1234, 4'h8);
      tick();
      rd(d, v);
      chk("keep_sync", d, 32'h5000_0000);
      rd(d, v);
      chk("keep_done", d, 32'h9000_0000);

      // nrst_out falls mid-window
      wr(32'h8000_0064, 4'hF);
      repeat (2) tick();
      mco2_in = 1'b1; tick();
      mco2_in = 1'b0;
      repeat (3) tick();
      nrst_in = 1'b0;
      repeat (2) tick();
      rd(d, v);
      chk("nrst_before", d, 32'h4000_0100);
      rd(d, v);
      chk("nrst_done", d, 32'hA000_0100);

      // Reset during COUNT discards measurement and err
      nrst_in = 1'b1;
      repeat (4) tick();
      wr(32'h8000_0064, 4'hF);
      repeat (4) tick();
      wr(32'h8000_0005, 4'hF);
      rd(d, v);
      chk("pre_rst_busy", d, 32'h7000_0000);
      rst = 1'b1;
      #2;
      chk("mid_rst_rdata", rdata, 32'h0);
      chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
      chk("mid_rst_wready", 32'(wready), 32'h1);
      rst = 1'b0;
      repeat (3) tick();
      rd(d, v);
      chk("post_rst", d, 32'h1000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
